// File: rtl/data_memory_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_pkg
//  Description : Shared constants and FSM encoding for the data memory block.
//  Revision    : 1.0
// ============================================================================
package data_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int c_LED_ADDR_DEFAULT = 1;
    localparam int c_WAIT_CNT_W       = 4;

endpackage
`default_nettype wire

// File: rtl/data_memory_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_array
//  Description : Word storage with synchronous read and byte-lane masked write.
//  Revision    : 1.0
// ============================================================================
module data_memory_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_we,
    input  logic                    i_re,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_wr_be,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    localparam int c_LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage itself carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_re) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory
//  Description : Word RAM with request/ready handshake, wait states, range
//                check and LED register. DATA_MEM_BYTE_EN adds byte lanes.
//  Revision    : 1.0
// ============================================================================
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 1,
    parameter int LED_ADDR    = c_LED_ADDR_DEFAULT,
    parameter int LED_COUNT   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    memRead,
    input  logic                    memWrite,
    input  logic [31:0]             location,
    input  logic [DATA_WIDTH-1:0]   value,
`ifdef DATA_MEM_BYTE_EN
    input  logic [DATA_WIDTH/8-1:0] byteEn,
`endif
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    ready,
    output logic                    busy,
    output logic                    error,
    output logic [LED_COUNT-1:0]    leds
);

    localparam int   c_LANES   = DATA_WIDTH / 8;
    localparam logic c_NO_WAIT = (WAIT_STATES == 0);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD =
        c_WAIT_CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_t                  r_state;
    logic [c_WAIT_CNT_W-1:0] r_count;
    logic [31:0]             r_loc;
    logic [DATA_WIDTH-1:0]   r_val;
    logic [c_LANES-1:0]      r_be;
    logic                    r_is_write;
    logic                    r_error;
    logic [LED_COUNT-1:0]    r_leds;

    logic [c_LANES-1:0]      w_be_in;
    logic [31:0]             w_loc;
    logic [DATA_WIDTH-1:0]   w_val;
    logic [c_LANES-1:0]      w_be;
    logic                    w_is_write;
    logic                    w_req_one;
    logic                    w_req_both;
    logic                    w_in_range;
    logic                    w_commit;
    logic                    w_we;
    logic                    w_re;
    logic                    w_led_we;

`ifdef DATA_MEM_BYTE_EN
    assign w_be_in = byteEn;
`else
    assign w_be_in = '1;
`endif

    assign w_req_one  = memRead ^ memWrite;
    assign w_req_both = memRead & memWrite;

    // With no wait states the access commits on the accepting edge, so the
    // live inputs feed the array directly; otherwise the latched copy does.
    always_comb begin
        w_loc      = r_loc;
        w_val      = r_val;
        w_be       = r_be;
        w_is_write = r_is_write;
        if (r_state == ST_IDLE) begin
            w_loc      = location;
            w_val      = value;
            w_be       = w_be_in;
            w_is_write = memWrite;
        end
    end

    assign w_in_range = ((w_loc >> ADDR_WIDTH) == 32'd0);
    assign w_commit   = !rst &&
                        (((r_state == ST_IDLE) && w_req_one && c_NO_WAIT) ||
                         ((r_state == ST_WAIT) && (r_count == '0)));
    assign w_we       = w_commit && w_is_write && w_in_range;
    assign w_re       = w_commit && !w_is_write && w_in_range;
    assign w_led_we   = w_we && (w_loc == 32'(LED_ADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_loc      <= '0;
            r_val      <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_error <= 1'b0;
                    if (w_req_both) begin
                        r_state <= ST_DONE;
                        r_error <= 1'b1;
                    end else if (w_req_one) begin
                        r_loc      <= location;
                        r_val      <= value;
                        r_be       <= w_be_in;
                        r_is_write <= memWrite;
                        if (c_NO_WAIT) begin
                            r_state <= ST_DONE;
                            r_error <= !w_in_range;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= c_WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                        r_error <= !w_in_range;
                    end else begin
                        r_count <= r_count - c_WAIT_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_error <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_leds <= '0;
        end else if (w_led_we) begin
            for (int i = 0; i < LED_COUNT; i++) begin
                if (w_be[i/8]) begin
                    r_leds[i] <= w_val[i];
                end
            end
        end
    end

    data_memory_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_re      (w_re),
        .i_addr    (w_loc[ADDR_WIDTH-1:0]),
        .i_wr_data (w_val),
        .i_wr_be   (w_be),
        .o_rd_data (out)
    );

    assign ready = (r_state == ST_DONE);
    assign error = ready & r_error;
    assign busy  = (r_state != ST_IDLE);
    assign leds  = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory
//  Description : Directed bench for data_memory with a cycle-level reference.
//  Revision    : 1.0
// ============================================================================
module tb_data_memory;

    localparam int c_WS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] location = '0, value = '0;
    logic [3:0]  be_drv = 4'hF;
    logic [31:0] out;
    logic        ready, busy, error;
    logic [3:0]  leds;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] loc0 = '0, val0 = '0;
    logic [31:0] out0;
    logic        ready0, busy0, error0;
    logic [3:0]  leds0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    data_memory #(.WAIT_STATES(c_WS)) dut (
        .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
        .location(location), .value(value),
`ifdef DATA_MEM_BYTE_EN
        .byteEn(be_drv),
`endif
        .out(out), .ready(ready), .busy(busy), .error(error), .leds(leds)
    );

    data_memory #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst), .memRead(rd0), .memWrite(wr0),
        .location(loc0), .value(val0),
`ifdef DATA_MEM_BYTE_EN
        .byteEn(4'hF),
`endif
        .out(out0), .ready(ready0), .busy(busy0), .error(error0), .leds(leds0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an accepted access occupies edges [accept, accept+WS] plus a
    // return-to-idle edge; conflicts complete on the accepting edge itself.
    int          cyc = 0;
    int          m_commit = -1;
    int          m_next_accept = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_mem [256];
    logic [31:0] m_out = '0;
    logic [3:0]  m_leds = '0;
    logic        p_valid = 1'b0, p_conf, p_wr;
    logic [31:0] p_loc, p_val;
    logic [3:0]  p_be;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            p_valid       = 1'b0;
            m_commit      = -1;
            m_next_accept = 0;
            m_out         = '0;
            m_leds        = '0;
        end else begin
            if (cyc >= m_next_accept && (memRead || memWrite)) begin
                p_valid = 1'b1;
                p_conf  = memRead && memWrite;
                p_wr    = memWrite;
                p_loc   = location;
                p_val   = value;
`ifdef DATA_MEM_BYTE_EN
                p_be    = be_drv;
`else
                p_be    = 4'hF;
`endif
                m_commit      = p_conf ? cyc : cyc + c_WS;
                m_next_accept = m_commit + 2;
            end
            if (p_valid && cyc == m_commit) begin
                p_valid = 1'b0;
                m_err   = p_conf || (p_loc > 32'd255);
                if (!m_err) begin
                    if (p_wr) begin
                        for (int i = 0; i < 4; i++)
                            if (p_be[i]) m_mem[p_loc[7:0]][8*i +: 8] = p_val[8*i +: 8];
                        if (p_loc == 32'd1)
                            for (int i = 0; i < 4; i++)
                                if (p_be[i/8]) m_leds[i] = p_val[i];
                    end else begin
                        m_out = m_mem[p_loc[7:0]];
                    end
                end
            end
        end
        #1;
        chk("busy",  {31'd0, busy},  {31'd0, cyc <= m_commit});
        chk("ready", {31'd0, ready}, {31'd0, cyc == m_commit});
        chk("error", {31'd0, error}, {31'd0, (cyc == m_commit) && m_err});
        chk("out",   out,            m_out);
        chk("leds",  {28'd0, leds},  {28'd0, m_leds});
    end

    task automatic access(input logic rd, input logic wr, input logic [31:0] loc,
                          input logic [31:0] val, input logic [3:0] be,
                          output int lat, output logic [31:0] r_out,
                          output logic r_err, output logic [3:0] r_leds);
        @(negedge clk);
        memRead = rd; memWrite = wr; location = loc; value = val; be_drv = be;
        lat = 0;
        do begin
            @(posedge clk); #2; lat++;
        end while (!ready && lat < 40);
        if (!ready) begin
            n_checks++; n_errors++;
            $display("FAIL timeout: no ready after %0d cycles, required ready=1", lat);
        end
        r_out = out; r_err = error; r_leds = leds;
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0;
    endtask

    int          lat;
    logic [31:0] o;
    logic        e;
    logic [3:0]  l;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'h0);
        chk("rst_leds", {28'd0, leds}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;

        access(0, 1, 32'd3, 32'h12345678, 4'hF, lat, o, e, l);
        chk("wr3_lat", lat, 32'd2);
        access(1, 0, 32'd3, 32'h0, 4'hF, lat, o, e, l);
        chk("rd3_lat", lat, 32'd2);
        chk("rd3_out", o, 32'h12345678);

        access(0, 1, 32'd1, 32'h0000000A, 4'hF, lat, o, e, l);
        chk("led_set", {28'd0, l}, 32'hA);
        access(0, 1, 32'd2, 32'h00000005, 4'hF, lat, o, e, l);
        chk("led_hold", {28'd0, l}, 32'hA);

        access(1, 0, 32'h100, 32'h0, 4'hF, lat, o, e, l);
        chk("oor_err", {31'd0, e}, 32'd1);
        chk("oor_out", o, 32'h12345678);

        access(1, 1, 32'd3, 32'h00000BAD, 4'hF, lat, o, e, l);
        chk("conf_lat", lat, 32'd1);
        chk("conf_err", {31'd0, e}, 32'd1);
        access(1, 0, 32'd3, 32'h0, 4'hF, lat, o, e, l);
        chk("conf_nowr", o, 32'h12345678);

        // Reset during the wait state of a write must drop it.
        access(0, 1, 32'd5, 32'hAAAA0000, 4'hF, lat, o, e, l);
        @(negedge clk);
        memWrite = 1'b1; location = 32'd5; value = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; memWrite = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'h0);
        chk("rstmid_leds", {28'd0, leds}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        access(1, 0, 32'd5, 32'h0, 4'hF, lat, o, e, l);
        chk("rstmid_rd5", o, 32'hAAAA0000);

        // A write raised (and location changed) mid-read waits for IDLE.
        @(negedge clk);
        memRead = 1'b1; location = 32'd3;
        @(posedge clk);
        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b1; location = 32'd9; value = 32'h00000099;
        lat = 0;
        do begin
            @(posedge clk); #2; lat++;
            if (lat == 1) chk("busy_rd_out", out, 32'h12345678);
        end while (!(ready && lat > 1) && lat < 40);
        chk("busy_defer_lat", lat, 32'd4);
        @(negedge clk);
        memWrite = 1'b0;
        access(1, 0, 32'd9, 32'h0, 4'hF, lat, o, e, l);
        chk("rd9_out", o, 32'h00000099);

`ifdef DATA_MEM_BYTE_EN
        access(0, 1, 32'd7, 32'hFFFFFFFF, 4'hF, lat, o, e, l);
        access(0, 1, 32'd7, 32'h00000000, 4'b0010, lat, o, e, l);
        access(1, 0, 32'd7, 32'h0, 4'b0000, lat, o, e, l);
        chk("be_rd7", o, 32'hFFFF00FF);
        access(0, 1, 32'd7, 32'h12345678, 4'b0000, lat, o, e, l);
        chk("be0_err", {31'd0, e}, 32'd0);
        access(1, 0, 32'd7, 32'h0, 4'hF, lat, o, e, l);
        chk("be0_rd7", o, 32'hFFFF00FF);
        access(0, 1, 32'd1, 32'h00000005, 4'b0000, lat, o, e, l);
        chk("be0_leds", {28'd0, l}, 32'hA);
`endif

        // Zero wait states: ready one cycle after accept.
        @(negedge clk);
        wr0 = 1'b1; loc0 = 32'd4; val0 = 32'h00000055;
        lat = 0;
        do begin @(posedge clk); #2; lat++; end while (!ready0 && lat < 20);
        chk("ws0_wr_lat", lat, 32'd1);
        chk("ws0_wr_busy", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        wr0 = 1'b0;
        @(negedge clk);
        rd0 = 1'b1;
        lat = 0;
        do begin @(posedge clk); #2; lat++; end while (!ready0 && lat < 20);
        chk("ws0_rd_lat", lat, 32'd1);
        chk("ws0_rd_out", out0, 32'h00000055);
        chk("ws0_err", {31'd0, error0}, 32'd0);
        @(negedge clk);
        rd0 = 1'b0;

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory.md
# data_memory

Parametrised, synchronous successor of the processor's data memory: a single-port word RAM with a request/ready handshake, programmable wait states, address range checking and a memory-mapped LED register. It sits between the core's memory stage and the board LEDs. Reads and writes complete a fixed number of cycles after acceptance. LED outputs mirror a dedicated register instead of a raw array word.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: word-address bits; depth is 2^ADDR_WIDTH words.
- WAIT_STATES, 1: extra cycles per access, 0..15.
- LED_ADDR, 1: word address whose writes also update the LED register.
- LED_COUNT, 4: number of LED outputs; must be ≤ DATA_WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- memRead  in  1  read request, level, sampled only in IDLE.
- memWrite  in  1  write request, level, sampled only in IDLE.
- location  in  32  word address.
- value  in  DATA_WIDTH  write data.
- byteEn  in  DATA_WIDTH/8  byte-lane write enables; present only with DATA_MEM_BYTE_EN.
- out  out  DATA_WIDTH  read data, registered.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  access in progress.
- error  out  1  one-cycle pulse with ready on a rejected access.
- leds  out  LED_COUNT  LED register bits [LED_COUNT-1:0].

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: if exactly one of memRead/memWrite is high, accept the request.
  - Latch location, value and byteEn.
  - Go to WAIT, or to DONE when WAIT_STATES=0.
- IDLE with memRead and memWrite both high: go to DONE with the error flag set. No array access.
- WAIT: a down-counter is loaded with WAIT_STATES-1 on accept. Go to DONE when it reaches 0.
- Access commits on the clock edge that enters DONE.
  - Read: out ← array[addr].
  - Write: array[addr] ← value.
- Range check: latched location[31:ADDR_WIDTH] ≠ 0 means out of range.
  - No array access, out unchanged, error=1 in DONE.
- DONE: ready=1 for one cycle, then return to IDLE unconditionally.
- A request still held in IDLE after ready starts a new access. The requester drops memRead/memWrite in the ready cycle.
- LED register: updated on a committed, in-range write to LED_ADDR, with the same lane masking as the array write.
- Signal definitions: busy = (state ≠ IDLE); ready and error are decoded from DONE.
- Array contents are not reset.
- out holds its last read value until the next successful read.

## Timing
- Reset values: state IDLE, out=0, ready=0, busy=0, error=0, leds=0, counter=0.
- Accept at edge N; busy high from N. ready is high in cycle N+1+WAIT_STATES; busy stays high through that cycle.
- Latency from accepting edge to ready = WAIT_STATES+1 cycles. Throughput = one access per WAIT_STATES+2 cycles.
- Read data on out is valid in the ready cycle and afterwards.
- Inputs are ignored while busy, including changes to location and value mid-access.
- Reset asserted mid-access: immediate return to IDLE. A pending write is dropped and the array is untouched.
- Address wrap: none. Out-of-range addresses are rejected, not truncated.

## Configuration
- DATA_MEM_BYTE_EN defined:
  - byteEn port exists.
  - Writes update only lanes with byteEn[i]=1, for both the array and the LED register.
  - A write with byteEn=0 completes normally (ready, no error) and changes nothing.
  - Reads ignore byteEn.
- DATA_MEM_BYTE_EN undefined: no byteEn port; every write is full-word.

## Structure
- Shared constant header holds:
  - FSM state encodings (IDLE, WAIT, DONE).
  - Default LED_ADDR.
  - Wait-state counter width (4).
- Sub-module data_memory_array holds the storage array with synchronous read and lane-masked write, parametrised by DATA_WIDTH/ADDR_WIDTH.
- FSM, counter, range check and LED register live in data_memory.

## Test plan
- Reset: rst=1 mid-WAIT of a write 0xDEADBEEF to 5 → busy=0, leds=0. A later read of 5 does not return 0xDEADBEEF (reads back the prior written value).
- Write then read, WAIT_STATES=1: write 0x12345678 to 3 → ready 2 cycles after accept. Read 3 → out=0x12345678 in its ready cycle.
- LED: write 0x0000000A to LED_ADDR=1 → leds=4'b1010 from the ready cycle onward. Write to 2 → leds unchanged.
- Out of range: read location=0x100 (ADDR_WIDTH=8) → ready=1, error=1 same cycle, out unchanged.
- Conflict and busy: memRead=memWrite=1 → error after 1 cycle, no write. A new request raised while busy is not accepted until IDLE.
- DATA_MEM_BYTE_EN: word 7 holds 0xFFFFFFFF; write value 0x00000000 with byteEn=4'b0010 → read 7 = 0xFFFF00FF. WAIT_STATES=0 gives ready 1 cycle after accept.
